// File: rtl/ps2_teclado.sv
// PS/2 keyboard receiver: conditions the raw clock/data lines, deframes 11-bit
// device-to-host frames and tracks the make code of the key currently held.
module ps2_teclado #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] tecla,
  output logic       tecla_nueva,
  output logic       err_trama
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, CHK = 2'd2} state_t;

  // Handshake: none. tecla is a held level; tecla_nueva and err_trama are
  // single-cycle, mutually exclusive strobes issued at the end of CHK.

  state_t          state_q, state_d;
  logic            c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic            fc_q, fc_d, fc_prev_q;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [10:0]     sh_q, sh_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      tecla_q, tecla_d;
  logic            brk_q, brk_d;
  logic            nueva_q, nueva_d;
  logic            err_q, err_d;
  logic            fall;
  logic            frame_ok;
  logic [7:0]      rx_byte;
  logic            tmo_hit;

  assign fall     = fc_prev_q & ~fc_q;
  assign rx_byte  = sh_q[8:1];
  // start low, stop high, odd parity over data + parity bit
  assign frame_ok = ~sh_q[0] & sh_q[10] & (^sh_q[9:1]);
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYC));

  // The filtered clock only follows the synchronized line after FILTER_LEN
  // consecutive samples disagreeing with it.
  always_comb begin
    fc_d   = fc_q;
    fcnt_d = '0;
    if (c_s2_q != fc_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) fc_d = c_s2_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fall) state_d = RX;
      RX: begin
        if (fall && bcnt_q == 4'd10) state_d = CHK;
        else if (!fall && tmo_hit)   state_d = IDLE;
      end
      CHK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: shift register, bit count and inter-edge timeout
  always_comb begin
    sh_d   = sh_q;
    bcnt_d = bcnt_q;
    tmo_d  = '0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          sh_d   = {d_s2_q, sh_q[10:1]};
          bcnt_d = 4'd1;
        end
      end
      RX: begin
        if (fall) begin
          sh_d   = {d_s2_q, sh_q[10:1]};
          bcnt_d = bcnt_q + 4'd1;
        end else if (tmo_hit) begin
          bcnt_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHK:     bcnt_d = '0;
      default: bcnt_d = '0;
    endcase
  end

  // Output logic: scan-code decoder acting on the frame checked in CHK
  always_comb begin
    tecla_d = tecla_q;
    brk_d   = brk_q;
    nueva_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == CHK) begin
      if (!frame_ok) begin
        err_d = 1'b1;
        brk_d = 1'b0;
      end else if (rx_byte == 8'hE0) begin
        brk_d = brk_q;
      end else if (rx_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        // a release only clears tecla if it names the key being held
        brk_d = 1'b0;
        if (rx_byte == tecla_q) tecla_d = 8'h00;
      end else begin
        tecla_d = rx_byte;
        nueva_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_s1_q    <= 1'b1;
      c_s2_q    <= 1'b1;
      d_s1_q    <= 1'b1;
      d_s2_q    <= 1'b1;
      fc_q      <= 1'b1;
      fc_prev_q <= 1'b1;
      fcnt_q    <= '0;
      sh_q      <= '0;
      bcnt_q    <= '0;
      tmo_q     <= '0;
      tecla_q   <= 8'h00;
      brk_q     <= 1'b0;
      nueva_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      c_s1_q    <= ps2c;
      c_s2_q    <= c_s1_q;
      d_s1_q    <= ps2d;
      d_s2_q    <= d_s1_q;
      fc_q      <= fc_d;
      fc_prev_q <= fc_q;
      fcnt_q    <= fcnt_d;
      sh_q      <= sh_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      tecla_q   <= tecla_d;
      brk_q     <= brk_d;
      nueva_q   <= nueva_d;
      err_q     <= err_d;
    end
  end

  assign tecla       = tecla_q;
  assign tecla_nueva = nueva_q;
  assign err_trama   = err_q;

endmodule

// File: tb/tb_ps2_teclado.sv
// Bench for ps2_teclado: drives PS/2 frames bit by bit and compares the held
// code and pulse counts against a key-state model after every frame.
module tb_ps2_teclado;

  localparam int FILT = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk;
  logic       reset_n;
  logic       ps2c;
  logic       ps2d;
  logic [7:0] tecla;
  logic       tecla_nueva;
  logic       err_trama;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_tecla = 8'h00;
  logic       m_brk   = 1'b0;
  int         m_nueva = 0;
  int         m_err   = 0;

  // observed pulse counts
  int   obs_nueva = 0;
  int   obs_err   = 0;
  logic prev_n    = 1'b0;
  logic prev_e    = 1'b0;

  logic [7:0] codes [6];

  ps2_teclado #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tecla       (tecla),
    .tecla_nueva (tecla_nueva),
    .err_trama   (err_trama)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor: width, exclusivity and counting
  always @(negedge clk) begin
    if (reset_n) begin
      if (tecla_nueva || err_trama) begin
        checks++;
        assert (!(tecla_nueva && err_trama) && !(tecla_nueva && prev_n) && !(err_trama && prev_e))
        else begin
          failures++;
          $error("FAIL pulse_shape got nueva=%0b err=%0b prev_n=%0b prev_e=%0b exp single exclusive pulse",
                 tecla_nueva, err_trama, prev_n, prev_e);
        end
      end
      if (tecla_nueva) obs_nueva++;
      if (err_trama)   obs_err++;
      prev_n = tecla_nueva;
      prev_e = err_trama;
    end else begin
      prev_n = 1'b0;
      prev_e = 1'b0;
    end
  end

  // model of the decoder, expressed as key-state rules
  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_brk) begin
      m_brk = 1'b0;
      if (b == m_tecla) m_tecla = 8'h00;
    end else begin
      m_tecla = b;
      m_nueva++;
    end
  endfunction

  function automatic void model_bad();
    m_err++;
    m_brk = 1'b0;
  endfunction

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic v);
    ps2d = v;
    wait_cyc(HALF);
    ps2c = 1'b0;
    wait_cyc(HALF);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input logic glitch);
    logic [10:0] fr;
    fr[0]    = 1'b0;
    fr[8:1]  = b;
    fr[9]    = (~^b) ^ bad_par;
    fr[10]   = ~bad_stop;
    for (int i = 0; i < 11; i++) begin
      send_bit(fr[i]);
      if (glitch && i == 4) begin
        wait_cyc(5);
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
      end
    end
    ps2d = 1'b1;
    wait_cyc(HALF);
    if (bad_par || bad_stop) model_bad();
    else                     model_byte(b);
  endtask

  task automatic send_partial(input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(i[0]);
    ps2d = 1'b1;
  endtask

  task automatic check_state(input string tag);
    checks++;
    assert (tecla === m_tecla)
    else begin
      failures++;
      $error("FAIL %s tecla got=%h exp=%h", tag, tecla, m_tecla);
    end
    checks++;
    assert (obs_nueva === m_nueva)
    else begin
      failures++;
      $error("FAIL %s nueva_count got=%0d exp=%0d", tag, obs_nueva, m_nueva);
    end
    checks++;
    assert (obs_err === m_err)
    else begin
      failures++;
      $error("FAIL %s err_count got=%0d exp=%0d", tag, obs_err, m_err);
    end
  endtask

  task automatic good(input logic [7:0] b, input string tag);
    send_frame(b, 1'b0, 1'b0, 1'b0);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    codes[0] = 8'h1C; codes[1] = 8'h1B; codes[2] = 8'h23;
    codes[3] = 8'h2B; codes[4] = 8'h24; codes[5] = 8'h3A;

    ps2c    = 1'b1;
    ps2d    = 1'b1;
    reset_n = 1'b0;
    #23;
    checks++;
    assert (tecla === 8'h00 && tecla_nueva === 1'b0 && err_trama === 1'b0)
    else begin
      failures++;
      $error("FAIL reset_vals got=%h/%0b/%0b exp=00/0/0", tecla, tecla_nueva, err_trama);
    end
    @(posedge clk);
    reset_n = 1'b1;
    wait_cyc(10);

    // make then break, plus a typematic repeat
    good(8'h24, "make_24");
    good(8'h24, "repeat_24");
    good(8'hF0, "f0_24");
    good(8'h24, "break_24");

    // overlapping keys
    good(8'h1E, "make_1e");
    good(8'h26, "make_26");
    good(8'hF0, "f0_1e");
    good(8'h1E, "break_1e_ignored");
    good(8'hF0, "f0_26");
    good(8'h26, "break_26");

    // parity error, then a bad stop that clears a pending break
    good(8'h1C, "make_1c_pre");
    send_frame(8'h4D, 1'b1, 1'b0, 1'b0);
    check_state("bad_parity_4d");
    good(8'hF0, "f0_before_bad");
    send_frame(8'h45, 1'b0, 1'b1, 1'b0);
    check_state("bad_stop");
    good(8'h45, "make_45_after_bad");

    // extended key
    good(8'hE0, "e0_make");
    good(8'h1C, "make_ext_1c");
    good(8'hE0, "e0_break");
    good(8'hF0, "f0_ext");
    good(8'h1C, "break_ext_1c");

    // timeout discards a partial frame silently
    send_partial(5);
    wait_cyc(TMO + 10);
    good(8'h16, "after_timeout_16");

    // glitch on clock mid-frame must not shift a bit
    send_frame(8'h36, 1'b0, 1'b0, 1'b1);
    check_state("glitch_36");

    // asynchronous reset mid-frame
    send_partial(5);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    m_tecla = 8'h00;
    m_brk   = 1'b0;
    checks++;
    assert (tecla === 8'h00 && tecla_nueva === 1'b0 && err_trama === 1'b0)
    else begin
      failures++;
      $error("FAIL async_reset got=%h/%0b/%0b exp=00/0/0", tecla, tecla_nueva, err_trama);
    end
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    good(8'h25, "after_reset_25");

    // randomized key traffic
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 5);
      b = codes[$urandom_range(0, 5)];
      case (r)
        0, 1: good(b, "rnd_make");
        2: begin
          if (m_tecla != 8'h00 && $urandom_range(0, 1) == 1) b = m_tecla;
          good(8'hF0, "rnd_f0");
          good(b, "rnd_break");
        end
        3: begin
          good(8'hE0, "rnd_e0");
          good(b, "rnd_ext");
        end
        4: begin
          if ($urandom_range(0, 1) == 1) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
          else                           send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
          check_state("rnd_bad");
        end
        default: begin
          good(8'hF0, "rnd_f0_bad");
          send_frame(b, 1'b1, 1'b0, 1'b0);
          check_state("rnd_bad_after_f0");
          good(b, "rnd_make_after_bad");
        end
      endcase
    end

    wait_cyc(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
